// File: rtl/rom24x8_read_arbiter_pkg.sv
// Shared types and constants for the 24x8 ROM read arbiter.
// ROM_ARB_RR_EN selects round-robin arbitration (default build: fixed priority).
package rom_arb_pkg;

  localparam int unsigned ADDR_W        = 5;
  localparam int unsigned BANK_SEL_LSB  = 3;
  localparam int unsigned NUM_BANKS_MAX = 4;
  localparam int unsigned BANK_SEL_W    = ADDR_W - BANK_SEL_LSB;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    RESP = 2'd2
  } state_e;

  // Accepted transaction: word address plus index of the granted requester.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              idx;
  } xact_t;

  function automatic logic [BANK_SEL_W-1:0] bank_of(input logic [ADDR_W-1:0] addr);
    return addr[ADDR_W-1:BANK_SEL_LSB];
  endfunction

  function automatic logic bank_ok(input logic [BANK_SEL_W-1:0] bank, input int unsigned nb);
    return (32'(bank) < nb) && (32'(bank) < NUM_BANKS_MAX);
  endfunction

endpackage

// File: rtl/rom24x8_read_arbiter_if.sv
// Requester-side request/response bundle of the ROM read arbiter.
interface rom24x8_read_arbiter_if #(
  parameter int unsigned NREQ   = 2,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 5
);

  logic [NREQ-1:0]        req_valid;
  logic [NREQ*ADDR_W-1:0] req_addr;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ-1:0]        rsp_valid;
  logic [NREQ-1:0]        rsp_ready;
  logic [DATA_W-1:0]      rsp_data;
  logic                   rsp_err;

  modport master (
    output req_valid, req_addr, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );

endinterface

// File: rtl/rom24x8_read_arbiter_pick.sv
// 2-way grant logic; ROM_ARB_RR_EN selects round-robin, otherwise requester 0 has fixed priority.
module rom_arb_pick (
`ifdef ROM_ARB_RR_EN
  input  logic       rr_ptr,
`endif
  input  logic [1:0] valid,
  output logic [1:0] gnt
);

`ifdef ROM_ARB_RR_EN
  // Favoured requester wins when valid, otherwise the other one.
  always_comb begin
    gnt = 2'b00;
    if (valid[rr_ptr]) begin
      gnt = rr_ptr ? 2'b10 : 2'b01;
    end else if (valid[~rr_ptr]) begin
      gnt = rr_ptr ? 2'b01 : 2'b10;
    end
  end
`else
  always_comb begin
    gnt = 2'b00;
    if (valid[0]) begin
      gnt = 2'b01;
    end else if (valid[1]) begin
      gnt = 2'b10;
    end
  end
`endif

endmodule

// File: rtl/rom24x8_read_arbiter.sv
// Shares one 24x8 ROM (three 8x8 banks) between two requesters; IDLE->READ->RESP per read.
// ROM_ARB_RR_EN enables round-robin arbitration; default is fixed priority to requester 0.
module rom24x8_read_arbiter
  import rom_arb_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned BANK_AW   = 3,
  parameter int unsigned NUM_BANKS = 3,
  parameter int unsigned NREQ      = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  rom24x8_read_arbiter_if.slave bus,
  output logic [NUM_BANKS-1:0] rom_cs,
  output logic                 rom_rd_en,
  output logic [BANK_AW-1:0]   rom_addr,
  input  logic [DATA_W-1:0]    rom_data0,
  input  logic [DATA_W-1:0]    rom_data1,
  input  logic [DATA_W-1:0]    rom_data2
);

  state_e                 state, state_d;
  xact_t                  xact, xact_d;
  logic [NREQ-1:0]        gnt;
  logic [ADDR_W-1:0]      win_addr;
  logic [BANK_SEL_W-1:0]  win_bank, cur_bank;
  logic [DATA_W-1:0]      bank_data;

  logic [NUM_BANKS-1:0]   rom_cs_d;
  logic                   rom_rd_en_d;
  logic [BANK_AW-1:0]     rom_addr_d;
  logic [NREQ-1:0]        rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]      rsp_data_q, rsp_data_d;
  logic                   rsp_err_q, rsp_err_d;

`ifdef ROM_ARB_RR_EN
  logic rr_ptr;

  // Pointer moves to the other requester after every accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= 1'b0;
    end else if (state == IDLE && |gnt) begin
      rr_ptr <= ~gnt[1];
    end
  end
`endif

  rom_arb_pick u_pick (
`ifdef ROM_ARB_RR_EN
    .rr_ptr (rr_ptr),
`endif
    .valid  (bus.req_valid),
    .gnt    (gnt)
  );

  assign win_addr = gnt[1] ? bus.req_addr[2*ADDR_W-1:ADDR_W] : bus.req_addr[ADDR_W-1:0];
  assign win_bank = bank_of(win_addr);
  assign cur_bank = bank_of(xact.addr);

  // Bank data mux for the transaction in flight.
  always_comb begin
    bank_data = '0;
    case (cur_bank)
      BANK_SEL_W'(0): bank_data = rom_data0;
      BANK_SEL_W'(1): bank_data = rom_data1;
      BANK_SEL_W'(2): bank_data = rom_data2;
      default:        bank_data = '0;
    endcase
  end

  // Next state and next register values.
  always_comb begin
    state_d       = state;
    xact_d        = xact;
    bus.req_ready = '0;
    rom_cs_d      = '0;
    rom_rd_en_d   = 1'b0;
    rom_addr_d    = '0;
    rsp_valid_d   = rsp_valid_q;
    rsp_data_d    = rsp_data_q;
    rsp_err_d     = rsp_err_q;

    case (state)
      IDLE: begin
        if (!rst && |gnt) begin
          bus.req_ready = gnt;
          xact_d.addr   = win_addr;
          xact_d.idx    = gnt[1];
          state_d       = READ;
          if (bank_ok(win_bank, NUM_BANKS)) begin
            rom_cs_d    = NUM_BANKS'(1) << win_bank;
            rom_rd_en_d = 1'b1;
            rom_addr_d  = win_addr[BANK_AW-1:0];
          end
        end
      end
      READ: begin
        state_d     = RESP;
        rsp_valid_d = NREQ'(1) << xact.idx;
        if (bank_ok(cur_bank, NUM_BANKS)) begin
          rsp_data_d = bank_data;
          rsp_err_d  = 1'b0;
        end else begin
          rsp_data_d = '0;
          rsp_err_d  = 1'b1;
        end
      end
      RESP: begin
        if (bus.rsp_ready[xact.idx]) begin
          rsp_valid_d = '0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d     = IDLE;
        rsp_valid_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      xact        <= '0;
      rom_cs      <= '0;
      rom_rd_en   <= 1'b0;
      rom_addr    <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state       <= state_d;
      xact        <= xact_d;
      rom_cs      <= rom_cs_d;
      rom_rd_en   <= rom_rd_en_d;
      rom_addr    <= rom_addr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_rom24x8_read_arbiter.sv
// Self-checking bench for rom24x8_read_arbiter: directed scenarios plus random traffic,
// every cycle compared against a transaction-level model (honours ROM_ARB_RR_EN).
module tb_rom24x8_read_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] rom_cs;
  logic       rom_rd_en;
  logic [2:0] rom_addr;
  logic [7:0] rom_data0, rom_data1, rom_data2;
  logic [7:0] mem [24];

  int n_checks = 0;
  int n_fail   = 0;

  // Model of the arbiter at transaction level.
  bit         m_busy;
  int         m_age;
  int         m_g;
  int         m_addr;
  int         m_rr;
  logic [7:0] m_data;
  logic       m_err;
  int         grants[$];

  rom24x8_read_arbiter_if #(.NREQ(2), .DATA_W(8), .ADDR_W(5)) bus ();

  rom24x8_read_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .rom_cs    (rom_cs),
    .rom_rd_en (rom_rd_en),
    .rom_addr  (rom_addr),
    .rom_data0 (rom_data0),
    .rom_data1 (rom_data1),
    .rom_data2 (rom_data2)
  );

  always #5 clk = ~clk;

  // Banks drive data combinationally, zero when deselected.
  always_comb begin
    rom_data0 = rom_cs[0] ? mem[{2'd0, rom_addr}] : 8'd0;
    rom_data1 = rom_cs[1] ? mem[{2'd1, rom_addr}] : 8'd0;
    rom_data2 = rom_cs[2] ? mem[{2'd2, rom_addr}] : 8'd0;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, want, $time);
    end
  endtask

  function automatic int winner(input logic [1:0] v, input int rr);
`ifdef ROM_ARB_RR_EN
    if (v[rr]) return rr;
    if (v[1-rr]) return 1 - rr;
    return -1;
`else
    if (v[0]) return 0;
    if (v[1]) return 1;
    return -1;
`endif
  endfunction

  // Apply reset for n edges with requests pending; outputs must read all-zero after each edge.
  task automatic do_reset(input int n);
    rst           = 1'b1;
    bus.req_valid = 2'b11;
    bus.req_addr  = 10'($urandom);
    bus.rsp_ready = 2'b00;
    repeat (n) begin
      @(posedge clk);
      #1;
      check("rst_ready", 32'(bus.req_ready), 32'd0);
      check("rst_cs",    32'(rom_cs),        32'd0);
      check("rst_rd_en", 32'(rom_rd_en),     32'd0);
      check("rst_raddr", 32'(rom_addr),      32'd0);
      check("rst_valid", 32'(bus.rsp_valid), 32'd0);
      check("rst_data",  32'(bus.rsp_data),  32'd0);
      check("rst_err",   32'(bus.rsp_err),   32'd0);
    end
    rst    = 1'b0;
    m_busy = 1'b0;
    m_age  = 0;
    m_rr   = 0;
    m_data = 8'd0;
    m_err  = 1'b0;
  endtask

  // One clock cycle: drive inputs, compare every output with the model, advance the model.
  task automatic cycle(input logic [1:0] v, input logic [4:0] a0, input logic [4:0] a1,
                       input logic [1:0] rr_in);
    int   w;
    bit   in_rng;
    logic [1:0] want_ready, want_valid;
    logic [2:0] want_cs, want_raddr;
    bit   rom_phase;
    bus.req_valid = v;
    bus.req_addr  = {a1, a0};
    bus.rsp_ready = rr_in;
    #1;
    w          = winner(v, m_rr);
    in_rng     = (m_addr < 24);
    rom_phase  = m_busy && (m_age == 1);
    want_ready = (!m_busy && w >= 0) ? (2'b01 << w) : 2'b00;
    want_cs    = (rom_phase && in_rng) ? (3'b001 << (m_addr / 8)) : 3'b000;
    want_raddr = (rom_phase && in_rng) ? 3'(m_addr % 8) : 3'd0;
    want_valid = (m_busy && m_age >= 2) ? (2'b01 << m_g) : 2'b00;
    check("ready", 32'(bus.req_ready), 32'(want_ready));
    check("cs",    32'(rom_cs),        32'(want_cs));
    check("rd_en", 32'(rom_rd_en),     32'(rom_phase && in_rng));
    check("raddr", 32'(rom_addr),      32'(want_raddr));
    check("valid", 32'(bus.rsp_valid), 32'(want_valid));
    check("data",  32'(bus.rsp_data),  32'(m_data));
    check("err",   32'(bus.rsp_err),   32'(m_err));
    if ((bus.req_ready & v) == 2'b01) grants.push_back(0);
    if ((bus.req_ready & v) == 2'b10) grants.push_back(1);
    if (!m_busy) begin
      if (w >= 0) begin
        m_busy = 1'b1;
        m_age  = 1;
        m_g    = w;
        m_addr = (w == 1) ? int'(a1) : int'(a0);
        m_rr   = 1 - w;
      end
    end else if (m_age == 1) begin
      m_age  = 2;
      m_data = (m_addr < 24) ? mem[m_addr] : 8'd0;
      m_err  = (m_addr >= 24);
    end else if (rr_in[m_g]) begin
      m_busy = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  // Single read from requester 0 with the response held for `hold` cycles.
  task automatic single_read(input logic [4:0] a, input int hold);
    cycle(2'b01, a, 5'd0, 2'b00);
    cycle(2'b00, 5'd0, 5'd0, 2'b00);
    repeat (hold) cycle(2'b00, 5'd0, 5'd0, 2'b00);
    cycle(2'b00, 5'd0, 5'd0, 2'b01);
    cycle(2'b00, 5'd0, 5'd0, 2'b00);
  endtask

  initial begin
    for (int i = 0; i < 24; i++) mem[i] = 8'($urandom);
    mem[1]  = 8'd255;
    mem[8]  = 8'd7;
    mem[23] = 8'd88;
    bus.req_valid = 2'b00;
    bus.req_addr  = '0;
    bus.rsp_ready = 2'b00;

    do_reset(2);

    single_read(5'd1, 3);
    check("d_addr1", 32'(bus.rsp_data), 32'd255);
    single_read(5'd8, 0);
    check("d_addr8", 32'(bus.rsp_data), 32'd7);
    single_read(5'd23, 1);
    check("d_addr23", 32'(bus.rsp_data), 32'd88);
    single_read(5'd26, 1);
    check("d_err26", 32'(bus.rsp_err), 32'd1);

    // Contention: both requesters hold valid, responses accepted at once.
    do_reset(1);
    grants.delete();
    repeat (12) cycle(2'b11, 5'd8, 5'd23, 2'b11);
    check("n_grants", 32'(grants.size()), 32'd4);
    for (int i = 0; i < 4 && i < grants.size(); i++) begin
`ifdef ROM_ARB_RR_EN
      check("grant_rr", 32'(grants[i]), 32'(i % 2));
`else
      check("grant_fix", 32'(grants[i]), 32'd0);
`endif
    end

    // Reset while a response is pending, then a normal read.
    cycle(2'b10, 5'd0, 5'd23, 2'b00);
    cycle(2'b00, 5'd0, 5'd0, 2'b00);
    cycle(2'b00, 5'd0, 5'd0, 2'b00);
    do_reset(1);
    single_read(5'd1, 1);

    // Random traffic, including rsp_ready for the wrong requester and dropped requests.
    for (int i = 0; i < 400; i++) begin
      cycle(2'($urandom), 5'($urandom), 5'($urandom), 2'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
